led_pattern_gen: RTL and testbench

- Multi-channel, run-time-configurable LED driver; generalises the single free-running-counter blinker.
- One shared prescaler produces a tick; each of NCH channels independently runs OFF, ON, BLINK (programmable half-period) or PWM (programmable duty).
- Sits between a simple control source (debug FSM or bus bridge) and board LED pins; the config interface is a valid/ready write port.

---
 rtl/led_pkg.sv | 19 +
 rtl/led_channel.sv | 75 +++++++
 rtl/led_pattern_gen.sv | 73 +++++++
 tb/tb_led_pattern_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: channel modes and a
// width helper used to size counters and the channel select.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its own mode/rate/duty and produces a registered
// drive that advances only on prescaler ticks.
module led_channel
  import led_pkg::*;
#(
  parameter int RATE_BITS = 8,
  parameter int DUTY_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 wr_en,
  input  logic [MODE_W-1:0]    mode,
  input  logic [RATE_BITS-1:0] rate,
  input  logic [DUTY_BITS-1:0] duty,
  output logic                 led
);

  localparam logic [RATE_BITS-1:0] RATE_ONE = RATE_BITS'(1);
  localparam logic [DUTY_BITS-1:0] DUTY_ONE = DUTY_BITS'(1);

  led_mode_e              mode_q;
  logic [RATE_BITS-1:0]   rate_q;
  logic [RATE_BITS-1:0]   cnt_q;
  logic [DUTY_BITS-1:0]   duty_q;
  logic [DUTY_BITS-1:0]   phase_q;
  logic [RATE_BITS-1:0]   rate_eff;
  logic                   blink_wrap;

  // A programmed rate of zero behaves as one tick per half-period.
  always_comb begin
    rate_eff   = (rate_q == '0) ? RATE_ONE : rate_q;
    blink_wrap = (cnt_q == (rate_eff - RATE_ONE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      rate_q  <= '0;
      duty_q  <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      led     <= 1'b0;
    end else if (wr_en) begin
      // A write takes priority over a coincident tick: counters restart.
      mode_q  <= led_mode_e'(mode);
      rate_q  <= rate;
      duty_q  <= duty;
      cnt_q   <= '0;
      phase_q <= '0;
      led     <= 1'b0;
    end else begin
      case (mode_q)
        MODE_OFF: led <= 1'b0;
        MODE_ON:  led <= 1'b1;
        MODE_BLINK: begin
          if (tick) begin
            if (blink_wrap) begin
              cnt_q <= '0;
              led   <= ~led;
            end else begin
              cnt_q <= cnt_q + RATE_ONE;
            end
          end
        end
        MODE_PWM: begin
          if (tick) phase_q <= phase_q + DUTY_ONE;
          led <= (phase_q < duty_q);
        end
        default: led <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared tick prescaler, config write port and
// one led_channel per output pin.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter  int NCH       = 4,
  parameter  int PRESCALE  = 1000,
  parameter  int RATE_BITS = 8,
  parameter  int DUTY_BITS = 8,
  localparam int CH_W      = width_of(NCH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic [CH_W-1:0]      i_cfg_ch,
  input  logic [MODE_W-1:0]    i_cfg_mode,
  input  logic [RATE_BITS-1:0] i_cfg_rate,
  input  logic [DUTY_BITS-1:0] i_cfg_duty,
  output logic                 o_tick,
  output logic [NCH-1:0]       o_led
);

  localparam int              PS_W    = width_of(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps_cnt;
  logic            cfg_fire;

  // Config handshake: a write transfers on any clock edge where
  // i_cfg_valid && o_cfg_ready. Ready is low only until the first edge after
  // reset release; there is no other backpressure. Writes to a channel index
  // at or beyond NCH transfer but match no channel and are dropped.
  assign cfg_fire = i_cfg_valid && o_cfg_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ps_cnt      <= '0;
      o_tick      <= 1'b0;
      o_cfg_ready <= 1'b0;
    end else begin
      o_cfg_ready <= 1'b1;
      if (ps_cnt == PS_LAST) begin
        ps_cnt <= '0;
        o_tick <= 1'b1;
      end else begin
        ps_cnt <= ps_cnt + PS_ONE;
        o_tick <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic wr_en;
    assign wr_en = cfg_fire && (i_cfg_ch == CH_W'(g));

    led_channel #(
      .RATE_BITS (RATE_BITS),
      .DUTY_BITS (DUTY_BITS)
    ) u_ch (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .tick  (o_tick),
      .wr_en (wr_en),
      .mode  (i_cfg_mode),
      .rate  (i_cfg_rate),
      .duty  (i_cfg_duty),
      .led   (o_led[g])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: per-edge expected {ready, tick, led} vectors
// derived from tick counts since each channel's last write.
module tb_led_pattern_gen;
  import led_pkg::*;

  localparam int NCH  = 4;
  localparam int P    = 4;
  localparam int RB   = 8;
  localparam int DB   = 4;
  localparam int NCH2 = 5;
  localparam int W    = NCH + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid, cfg_ready;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [RB-1:0] cfg_rate;
  logic [DB-1:0] cfg_duty;
  logic          tick;
  logic [NCH-1:0] led;

  logic            valid2, ready2, tick2;
  logic [2:0]      ch2;
  logic [NCH2-1:0] led2;

  int n_checks = 0;
  int n_fail   = 0;

  // expected-result scoreboard and spec model state
  logic [W-1:0] exp_q[$];
  int n_edge;
  int m_mode[NCH], m_rate[NCH], m_duty[NCH], tk[NCH], tkp[NCH];
  logic [NCH-1:0] m_led;

  always #5 clk = ~clk;

  led_pattern_gen #(.NCH(NCH), .PRESCALE(P), .RATE_BITS(RB), .DUTY_BITS(DB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_ch(cfg_ch), .i_cfg_mode(cfg_mode), .i_cfg_rate(cfg_rate),
    .i_cfg_duty(cfg_duty), .o_tick(tick), .o_led(led)
  );

  led_pattern_gen #(.NCH(NCH2), .PRESCALE(P), .RATE_BITS(RB), .DUTY_BITS(DB)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(valid2), .o_cfg_ready(ready2),
    .i_cfg_ch(ch2), .i_cfg_mode(cfg_mode), .i_cfg_rate(cfg_rate),
    .i_cfg_duty(cfg_duty), .o_tick(tick2), .o_led(led2)
  );

  task automatic model_reset();
    n_edge = 0;
    m_led  = '0;
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_rate[c] = 0; m_duty[c] = 0; tk[c] = 0; tkp[c] = 0;
    end
    exp_q.delete();
  endtask

  // Predict the effect of the next edge, push it, take the edge, pop & compare.
  task automatic step();
    logic [W-1:0] want, got;
    bit tick_edge, wr, et;
    int e, r;
    e         = n_edge + 1;
    tick_edge = (n_edge >= 1) && (n_edge % P == 0);
    wr        = cfg_valid && (n_edge >= 1);
    for (int c = 0; c < NCH; c++) begin
      if (wr && int'(cfg_ch) == c) begin
        m_mode[c] = int'(cfg_mode); m_rate[c] = int'(cfg_rate);
        m_duty[c] = int'(cfg_duty); tk[c] = 0; tkp[c] = 0; m_led[c] = 1'b0;
      end else begin
        tkp[c] = tk[c];
        if (tick_edge) tk[c]++;
        case (m_mode[c])
          0: m_led[c] = 1'b0;
          1: m_led[c] = 1'b1;
          2: begin
            r = (m_rate[c] == 0) ? 1 : m_rate[c];
            m_led[c] = ((tk[c] / r) % 2) == 1;
          end
          default: m_led[c] = (tkp[c] % (1 << DB)) < m_duty[c];
        endcase
      end
    end
    et = (e % P == 0);
    exp_q.push_back({1'b1, et, m_led});
    @(posedge clk); #1;
    n_edge = e;
    want = exp_q.pop_front();
    got  = {cfg_ready, tick, led};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL sb_ready_tick_led edge=%0d got=%b exp=%b", n_edge, got, want);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg_write(input int ch, input int mode, input int rate, input int duty);
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_rate  = RB'(rate);
    cfg_duty  = DB'(duty);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic write2(input int ch, input int mode);
    ch2      = 3'(ch);
    cfg_mode = 2'(mode);
    valid2   = 1'b1;
    step();
    valid2   = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({cfg_ready, tick, led} !== '0) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", name, {cfg_ready, tick, led}, {W{1'b0}});
    end
    n_checks++;
    if (led2 !== '0) begin
      n_fail++;
      $display("FAIL %s_dut2 got=%b exp=%b", name, led2, {NCH2{1'b0}});
    end
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_values");
    release_reset();
    check_idle_outputs("release_cycle0");
    steps(100);
  endtask

  task automatic test_on_off();
    cfg_write(0, MODE_ON, 0, 0);
    cfg_write(3, MODE_OFF, 0, 0);
    steps(10);
  endtask

  task automatic test_blink();
    cfg_write(1, MODE_BLINK, 3, 0);
    steps(100);
    cfg_write(1, MODE_BLINK, 0, 0);
    steps(40);
  endtask

  task automatic test_pwm();
    int duties[3] = '{5, 0, 15};
    int high;
    for (int d = 0; d < 3; d++) begin
      cfg_write(2, MODE_PWM, 0, duties[d]);
      steps(8);
      high = 0;
      for (int i = 0; i < 16 * P; i++) begin
        step();
        if (led[2] === 1'b1) high++;
      end
      n_checks++;
      if (high != duties[d] * P) begin
        n_fail++;
        $display("FAIL pwm_high_clocks duty=%0d got=%0d exp=%0d", duties[d], high, duties[d] * P);
      end
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    // line up a rewrite of a lit blink channel with an edge that carries a tick
    while (!((n_edge % P == 0) && m_led[1] == 1'b1) && guard < 64) begin
      step();
      guard++;
    end
    n_checks++;
    if (guard >= 64) begin
      n_fail++;
      $display("FAIL align_tick_rewrite got=timeout exp=aligned");
    end
    cfg_write(1, MODE_BLINK, 2, 0);
    n_checks++;
    if (led[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rewrite_forces_low got=%b exp=0", led[1]);
    end
    steps(20);
    cfg_write(0, MODE_OFF, 0, 0);
    cfg_write(3, MODE_ON, 0, 0);
    steps(10);
  endtask

  task automatic test_bad_channel();
    write2(0, MODE_ON);
    write2(5, MODE_ON);
    write2(7, MODE_PWM);
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (led2 !== 5'b00001) begin
        n_fail++;
        $display("FAIL bad_channel_ignored got=%b exp=00001", led2);
      end
    end
    write2(4, MODE_ON);
    step();
    n_checks++;
    if (led2 !== 5'b10001) begin
      n_fail++;
      $display("FAIL last_valid_channel got=%b exp=10001", led2);
    end
  endtask

  task automatic test_reset_mid();
    cfg_write(0, MODE_ON, 0, 0);
    cfg_write(1, MODE_BLINK, 1, 0);
    steps(13);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    repeat (3) @(posedge clk);
    release_reset();
    steps(30);
    cfg_write(0, MODE_ON, 0, 0);
    steps(5);
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_rate = '0; cfg_duty = '0; valid2 = 1'b0; ch2 = '0;
    model_reset();
    test_reset();
    test_on_off();
    test_blink();
    test_pwm();
    test_back_to_back();
    test_bad_channel();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
